// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Instruction fetch stage with a DEPTH-entry {pc, instr} prefetch
//            queue and taken-branch redirect/flush. Optional macro
//            FETCH_QUEUE_BYPASS_EN forwards a fetch straight to the output
//            when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready
);

  localparam int              c_ptr_w = $clog2(DEPTH);
  localparam int              c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [63:0]        r_fetch_pc;
  logic [63:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_write;
  logic w_bypass;

  assign imem_addr = r_fetch_pc;

  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == c_full);
    // A full queue never requests, even when a pop frees a slot this cycle.
    imem_req = reset && !w_full && !redirect;
    w_push   = imem_req && imem_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass  = w_empty && w_push;
    out_valid = reset && !redirect && (!w_empty || w_bypass);
    out_instr = w_bypass ? imem_data  : r_instr_mem[r_rd_ptr];
    out_pc    = w_bypass ? r_fetch_pc : r_pc_mem[r_rd_ptr];
`else
    w_bypass  = 1'b0;
    out_valid = reset && !redirect && !w_empty;
    out_instr = r_instr_mem[r_rd_ptr];
    out_pc    = r_pc_mem[r_rd_ptr];
`endif
    // A bypassed word that is consumed at once never occupies a slot.
    w_pop   = out_valid && out_ready && !w_bypass;
    w_write = w_push && !(w_bypass && out_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end
      if (w_write) begin
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        r_instr_mem[r_wr_ptr] <= imem_data;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_write && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Self-checking bench for instr_fetch_queue using a reference
//            queue scoreboard plus directed scenario checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int c_lat    = 0;
  localparam bit c_bypass = 1'b1;
`else
  localparam int c_lat    = 1;
  localparam bit c_bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [63:0] m_pc;

  always #5 clk = ~clk;

  assign imem_data = 32'hF800_0000 + imem_addr[31:0];

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_ready  (out_ready)
  );

  // Scoreboard: fetched words are queued as expected output, and each
  // accepted output is compared against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   e_req, e_byp, e_valid;
      ent_t head;
      e_req   = reset && (sb.size() != DEPTH) && !redirect;
      e_byp   = c_bypass && (sb.size() == 0) && e_req && imem_ready;
      e_valid = reset && !redirect && ((sb.size() != 0) || e_byp);
      n_tests++;
      if (imem_req !== e_req) begin
        n_fail++;
        $display("FAIL sb_imem_req t=%0t: got %b expected %b", $time, imem_req, e_req);
      end
      if (e_req) begin
        n_tests++;
        if (imem_addr !== m_pc) begin
          n_fail++;
          $display("FAIL sb_imem_addr t=%0t: got %h expected %h", $time, imem_addr, m_pc);
        end
      end
      n_tests++;
      if (out_valid !== e_valid) begin
        n_fail++;
        $display("FAIL sb_out_valid t=%0t: got %b expected %b", $time, out_valid, e_valid);
      end
      if (e_valid) begin
        head = e_byp ? ent_t'{m_pc, 32'hF800_0000 + m_pc[31:0]} : sb[0];
        n_tests++;
        if (out_pc !== head.pc || out_instr !== head.instr) begin
          n_fail++;
          $display("FAIL sb_out_entry t=%0t: got pc=%h instr=%h expected pc=%h instr=%h",
                   $time, out_pc, out_instr, head.pc, head.instr);
        end
      end
      if (!reset) begin
        sb.delete();
        m_pc = RESET_PC;
      end else if (redirect) begin
        sb.delete();
        m_pc = redirect_pc;
      end else begin
        if (e_valid && out_ready && !e_byp) void'(sb.pop_front());
        if (e_req && imem_ready) begin
          if (!(e_byp && out_ready)) sb.push_back(ent_t'{m_pc, 32'hF800_0000 + m_pc[31:0]});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input logic [63:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    imem_ready  = 1'b0;
    out_ready   = 1'b0;
    cyc();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    imem_ready  = 1'b1;
    out_ready   = 1'b1;
    cyc();
    cyc();
    n_tests++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid: got req=%b valid=%b expected 0 0", imem_req, out_valid);
    end
    n_tests++;
    if (out_pc !== 64'h0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out_data: got pc=%h instr=%h expected 0 0", out_pc, out_instr);
    end
    n_tests++;
    if (imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected %h", imem_addr, RESET_PC);
    end
    sb.delete();
    m_pc   = RESET_PC;
    mon_en = 1'b1;
    reset  = 1'b1;
  endtask

  task automatic test_stream();
    logic [63:0] a   [6];
    logic [63:0] p   [6];
    logic [31:0] ins [6];
    logic        v   [6];
    logic [63:0] e_addr [3];
    e_addr[0] = 64'h0; e_addr[1] = 64'h4; e_addr[2] = 64'h8;
    for (int i = 0; i < 3 + c_lat; i++) begin
      @(negedge clk);
      a[i] = imem_addr; p[i] = out_pc; ins[i] = out_instr; v[i] = out_valid;
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (a[i] !== e_addr[i]) begin
        n_fail++;
        $display("FAIL stream_addr[%0d]: got %h expected %h", i, a[i], e_addr[i]);
      end
      n_tests++;
      if (v[i+c_lat] !== 1'b1 || p[i+c_lat] !== e_addr[i] ||
          ins[i+c_lat] !== 32'hF800_0000 + e_addr[i][31:0]) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, v[i+c_lat], p[i+c_lat], ins[i+c_lat], e_addr[i], 32'hF800_0000 + e_addr[i][31:0]);
      end
    end
    if (c_lat == 1) begin
      n_tests++;
      if (v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_first_valid: got %b expected 0", v[0]);
      end
    end
  endtask

  task automatic test_fill_stall();
    flush(64'h0);
    imem_ready = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (imem_req !== (i < 4)) begin
        n_fail++;
        $display("FAIL fill_req[%0d]: got %b expected %b", i, imem_req, (i < 4));
      end
      if (i < 4) begin
        n_tests++;
        if (imem_addr !== 64'(4 * i)) begin
          n_fail++;
          $display("FAIL fill_addr[%0d]: got %h expected %h", i, imem_addr, 64'(4 * i));
        end
      end
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pop: got v=%b pc=%h req=%b expected v=1 pc=0 req=0", out_valid, out_pc, imem_req);
    end
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin
      n_fail++;
      $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr);
    end
    cyc();
    imem_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drained: got valid=%b expected 0", out_valid);
    end
    cyc();
  endtask

  task automatic test_wait_states();
    logic        rdy [4];
    logic [63:0] ea  [4];
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1;
    ea[0] = 64'h0; ea[1] = 64'h4; ea[2] = 64'h4; ea[3] = 64'h4;
    flush(64'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ready = rdy[i];
      @(negedge clk);
      n_tests++;
      if (imem_addr !== ea[i]) begin
        n_fail++;
        $display("FAIL wait_addr[%0d]: got %h expected %h", i, imem_addr, ea[i]);
      end
      cyc();
    end
    imem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_addr !== 64'h8 || out_pc !== 64'h0) begin
      n_fail++;
      $display("FAIL wait_after: got addr=%h pc=%h expected addr=8 pc=0", imem_addr, out_pc);
    end
    cyc();
    out_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_count: got valid=%b after two pops expected 0", out_valid);
    end
    cyc();
  endtask

  task automatic test_redirect_flush();
    bit found;
    flush(64'h0);
    imem_ready = 1'b1;
    out_ready  = 1'b0;
    repeat (3) cyc();
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    out_ready   = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: got v=%b req=%b expected 0 0", out_valid, imem_req);
    end
    cyc();
    redirect  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h100) begin
      n_fail++;
      $display("FAIL flush_after: got v=%b addr=%h expected v=0 addr=100", out_valid, imem_addr);
    end
    cyc();
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && !found) begin
        found = 1'b1;
        n_tests++;
        if (out_pc !== 64'h100) begin
          n_fail++;
          $display("FAIL flush_first_pc: got %h expected 100", out_pc);
        end
      end
      cyc();
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL flush_timeout: got no out_valid expected one within 4 cycles");
    end
    flush(64'h0);
  endtask

  task automatic test_redirect_push_pop();
    flush(64'h0);
    imem_ready = 1'b1;
    out_ready  = 1'b0;
    repeat (2) cyc();
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rpp_cycle: got req=%b v=%b expected 0 0", imem_req, out_valid);
    end
    cyc();
    redirect   = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h200) begin
      n_fail++;
      $display("FAIL rpp_empty: got v=%b addr=%h expected v=0 addr=200", out_valid, imem_addr);
    end
    cyc();
  endtask

  task automatic test_wrap();
    logic [63:0] ea [4];
    ea[0] = 64'hFFFF_FFFF_FFFF_FFF8; ea[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    ea[2] = 64'h0;                   ea[3] = 64'h4;
    flush(64'hFFFF_FFFF_FFFF_FFF8);
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (imem_addr !== ea[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %h expected %h", i, imem_addr, ea[i]);
      end
      cyc();
    end
    flush(64'h0);
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    repeat (3) cyc();
    reset       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h300;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_cycle: got req=%b v=%b expected 0 0", imem_req, out_valid);
    end
    cyc();
    reset    = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL rstmid_pc: got %h expected %h", imem_addr, RESET_PC);
    end
    cyc();
    flush(64'h0);
  endtask

  task automatic test_bypass();
    flush(64'h40);
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== c_bypass) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got v=%b expected %b", out_valid, c_bypass);
    end
    if (c_bypass) begin
      n_tests++;
      if (out_pc !== 64'h40 || out_instr !== 32'hF800_0040) begin
        n_fail++;
        $display("FAIL bypass_data: got pc=%h instr=%h expected 40 f8000040", out_pc, out_instr);
      end
    end
    cyc();
    imem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== !c_bypass) begin
      n_fail++;
      $display("FAIL bypass_count: got v=%b expected %b", out_valid, !c_bypass);
    end
    cyc();
    flush(64'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = {$urandom, $urandom} & ~64'h3;
      cyc();
    end
    redirect = 1'b0;
    flush(64'h0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_stall();
    test_wait_states();
    test_redirect_flush();
    test_redirect_push_pop();
    test_wrap();
    test_reset_mid();
    test_bypass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage with a prefetch queue, sitting between the instruction memory and the decode/control logic of the LEGv8 datapath. It owns the fetch PC and issues sequential word fetches while queue space exists. It buffers up to DEPTH {pc, instruction} pairs and hands them downstream with a valid/ready handshake. A taken branch redirects the fetch PC and flushes all buffered entries.

## Interface
- DEPTH, 4, queue entries; must be a power of two and at least 2.
- RESET_PC, 64'h0, fetch PC loaded on reset.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch address; equals the internal fetch PC.
- imem_ready  in  1  memory returns imem_data in the same cycle as imem_req.
- imem_data  in  32  fetched instruction word.
- redirect  in  1  taken-branch strobe from the branch mux (branch & zero).
- redirect_pc  in  64  branch target.
- out_valid  out  1  out_instr and out_pc hold a valid entry.
- out_instr  out  32  instruction at the queue head.
- out_pc  out  64  PC of out_instr.
- out_ready  in  1  consumer accepts the head entry this cycle.

## Operation
- State:
  - fetch_pc (64).
  - DEPTH-entry storage of {pc[63:0], instr[31:0]}.
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
- Request: imem_req = (count != DEPTH) && !redirect. A full queue does not request, even if a pop happens in the same cycle.
- Push occurs when imem_req && imem_ready:
  - Write {fetch_pc, imem_data} at wr_ptr.
  - Increment wr_ptr.
  - Set fetch_pc = fetch_pc + 4, truncated to 64 bits and wrapping past 2^64-4.
- Pop occurs when out_valid && out_ready. It increments rd_ptr.
- Push and pop in the same cycle leave count unchanged. Push alone increments count; pop alone decrements it.
- out_valid = (count != 0) && !redirect. out_instr and out_pc show the head entry combinationally. When out_valid is 0, they hold the last head contents and are don't-care.
- Redirect has priority over everything else:
  - fetch_pc is set to redirect_pc.
  - count, wr_ptr and rd_ptr are cleared.
  - Any push or pop in that cycle is discarded.
- redirect held high for N cycles keeps the queue empty, with no requests, for N cycles. The last redirect_pc value wins.
- imem_ready without imem_req is ignored.

## Timing
- Reset values (reset low at a clock edge):
  - fetch_pc = RESET_PC, count = 0, pointers = 0.
  - Outputs: imem_req = 0 while reset is low, out_valid = 0, out_instr = 0, out_pc = 0.
- First request: imem_addr = RESET_PC in the first cycle after reset rises.
- Fetch-to-output latency, queue empty, bypass off: 1 cycle. Data pushed at edge N is presented with out_valid in cycle N+1.
- Throughput: one instruction per cycle while imem_ready stays high and the consumer keeps up.
- Full queue stalls fetch for one cycle after the pop that frees an entry.
- Redirect latency: redirect asserted in cycle N gives imem_addr = redirect_pc in cycle N+1. The earliest out_valid for the target is cycle N+2, or N+1 with bypass.
- Reset asserted mid-operation overrides a redirect in the same cycle.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - Bypass condition: count == 0 and a push is occurring.
  - Then out_valid = 1, out_instr = imem_data, out_pc = fetch_pc, combinationally in the same cycle.
  - If out_ready is also high, the word is consumed and not written into the queue; count stays 0.
  - If out_ready is low, the word is pushed normally.
  - The combinational path imem_data -> out_instr exists only with this macro defined.
- Not defined: no combinational path from any imem_* input to the out_* outputs; latency is as stated above.

## Test plan
- Reset and stream:
  - Stimulus: reset low for 2 cycles, then high; imem_ready = 1, out_ready = 1, memory returns 32'hF8000000 + addr.
  - Required: imem_addr = 0, 4, 8 on consecutive cycles; out_pc = 0, 4, 8 one cycle later, each with the matching out_instr.
- Fill and stall:
  - Stimulus: out_ready = 0, imem_ready = 1, DEPTH = 4.
  - Required: four pushes, PCs 0..12; then imem_req = 0 and count = 4. Raising out_ready pops PC 0, and the next request issues one cycle later at addr 16.
- Memory wait states:
  - Stimulus: imem_ready toggles 1, 0, 0, 1.
  - Required: imem_addr holds at 4 during the low cycles; no entry is pushed and count is unchanged.
- Redirect flush:
  - Stimulus: queue holds 3 entries; redirect = 1 with redirect_pc = 64'h100 for one cycle, with out_ready = 1.
  - Required: out_valid = 0 that cycle and no pop counted; next cycle count = 0 and imem_addr = 64'h100; first out_pc after flush = 64'h100.
- Redirect with push and pop:
  - Stimulus: redirect coincides with imem_ready = 1 and out_ready = 1.
  - Required: the fetched word is dropped and the queue is empty after the edge.
- Bypass (macro defined):
  - Stimulus: queue empty, imem_ready = 1, out_ready = 1.
  - Required: out_valid = 1 in the same cycle as imem_addr = 0, and count stays 0.
